// File: rtl/cv32e40p_register_file_mp.sv
// Multi-ported flip-flop register file with a one-entry write buffer, optional
// same-cycle bypass, optional FP bank and a sequential bulk-clear engine.

module cv32e40p_rf_rd_port #(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_WR_PORTS  = 2,
  parameter int NUM_TOT_WORDS = 32,
  parameter int IDXW          = 5,
  parameter int FP_EN         = 0,
  parameter int BYPASS        = 0
) (
  input  logic [ADDR_WIDTH-1:0]                      raddr,
  input  logic [NUM_TOT_WORDS-1:0][DATA_WIDTH-1:0]   mem,
  input  logic [NUM_WR_PORTS-1:0]                    wb_vld,
  input  logic [NUM_WR_PORTS-1:0][ADDR_WIDTH-1:0]    wb_addr,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]    wb_data,
  input  logic [NUM_WR_PORTS-1:0]                    live_vld,
  input  logic [NUM_WR_PORTS-1:0][ADDR_WIDTH-1:0]    waddr,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]                      rdata
);
  // Later assignments win: array < buffer < live bypass < x0/absent-bank zero.
  always_comb begin
    rdata = mem[raddr[IDXW-1:0]];
    for (int p = 0; p < NUM_WR_PORTS; p++)
      if (wb_vld[p] && wb_addr[p] == raddr) rdata = wb_data[p];
    if (BYPASS != 0)
      for (int p = 0; p < NUM_WR_PORTS; p++)
        if (live_vld[p] && waddr[p] == raddr) rdata = wdata[p];
    if (raddr[5] ? (FP_EN == 0) : (raddr[4:0] == 5'd0)) rdata = '0;
  end
endmodule

module cv32e40p_register_file_mp #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 3,
  parameter int NUM_WR_PORTS = 2,
  parameter int FPU          = 0,
  parameter int ZFINX        = 0,
  parameter int BYPASS       = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
  input  logic [NUM_WR_PORTS-1:0][ADDR_WIDTH-1:0]   waddr_i,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_WR_PORTS-1:0]                   we_i,
  input  logic                                      clear_req_i,
  output logic                                      clear_ack_o,
  output logic                                      busy_o
);
  localparam int FP_EN         = (FPU == 1 && ZFINX == 0) ? 1 : 0;
  localparam int NUM_TOT_WORDS = FP_EN ? 64 : 32;
  localparam int IDXW          = FP_EN ? 6 : 5;
  localparam logic [5:0] LAST  = 6'(NUM_TOT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                                  state;
  logic [5:0]                              cnt;
  logic                                    hold;
  logic [NUM_TOT_WORDS-1:0][DATA_WIDTH-1:0] mem;
  logic [NUM_WR_PORTS-1:0]                 wb_vld;
  logic [NUM_WR_PORTS-1:0][ADDR_WIDTH-1:0] wb_addr;
  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wb_data;
  logic [NUM_WR_PORTS-1:0]                 live_vld, cap_vld;
  logic                                    start_clr;

  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    if (a[5]) return 1'(FP_EN);
    return a[4:0] != 5'd0;
  endfunction

  assign busy_o      = (state == CLEAR);
  assign clear_ack_o = (state == DONE);
  assign start_clr   = (state == IDLE) && clear_req_i && !hold;

  // A lower port loses to any higher port targeting the same register.
  always_comb begin
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      live_vld[p] = we_i[p] && !busy_o && writable(waddr_i[p]);
      cap_vld[p]  = live_vld[p];
      for (int q = p + 1; q < NUM_WR_PORTS; q++)
        if (live_vld[q] && waddr_i[q] == waddr_i[p]) cap_vld[p] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      hold    <= 1'b0;
      mem     <= '0;
      wb_vld  <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          mem[cnt[IDXW-1:0]] <= '0;
          cnt    <= cnt + 6'd1;
          wb_vld <= '0;
          if (cnt == LAST) state <= DONE;
        end
        IDLE, DONE: begin
          // A request still high at completion must drop before it can rearm.
          if (state == DONE) begin
            state <= IDLE;
            hold  <= clear_req_i;
          end else if (!clear_req_i) begin
            hold <= 1'b0;
          end
          if (start_clr) begin
            state  <= CLEAR;
            cnt    <= '0;
            wb_vld <= '0;
          end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++)
              if (wb_vld[p]) mem[wb_addr[p][IDXW-1:0]] <= wb_data[p];
            wb_vld  <= cap_vld;
            wb_addr <= waddr_i;
            wb_data <= wdata_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
    cv32e40p_rf_rd_port #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WR_PORTS(NUM_WR_PORTS),
      .NUM_TOT_WORDS(NUM_TOT_WORDS), .IDXW(IDXW), .FP_EN(FP_EN), .BYPASS(BYPASS)
    ) u_rd (
      .raddr(raddr_i[r]), .mem(mem), .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
      .live_vld(live_vld), .waddr(waddr_i), .wdata(wdata_i), .rdata(rdata_o[r])
    );
  end
endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// Scoreboard bench driving three configurations in lockstep:
// dut0 default, dut1 FPU+BYPASS, dut2 FPU+ZFINX.

module tb_cv32e40p_register_file_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0][5:0]  raddr = '0;
  logic [1:0][5:0]  waddr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0]       we = '0;
  logic             clear_req = 1'b0;
  logic [2:0][31:0] rdata0, rdata1, rdata2;
  logic [2:0]       busy, ack;
  logic [31:0]      rd [3][3];

  typedef struct { int d; int p; logic [31:0] v; } exp_t;
  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cv32e40p_register_file_mp dut0 (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata0), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .clear_req_i(clear_req), .clear_ack_o(ack[0]), .busy_o(busy[0]));
  cv32e40p_register_file_mp #(.FPU(1), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata1), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .clear_req_i(clear_req), .clear_ack_o(ack[1]), .busy_o(busy[1]));
  cv32e40p_register_file_mp #(.FPU(1), .ZFINX(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata2), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .clear_req_i(clear_req), .clear_ack_o(ack[2]), .busy_o(busy[2]));

  always_comb
    for (int i = 0; i < 3; i++) begin
      rd[0][i] = rdata0[i];
      rd[1][i] = rdata1[i];
      rd[2][i] = rdata2[i];
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int p, input logic [31:0] v);
    exp_t e;
    e.d = d; e.p = p; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic push_all(input int d, input logic [31:0] v);
    for (int p = 0; p < 3; p++) push(d, p, v);
  endtask

  task automatic test_reset();
    int bc[3], ac[3];
    exp_t e;
    rst_n = 1'b0; we = '0; clear_req = 1'b0;
    raddr[0] = 6'd0; raddr[1] = 6'd1; raddr[2] = 6'd5;
    #12;
    n_chk++;
    if (busy !== 3'b111 || ack !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: busy=%b ack=%b want busy=111 ack=000", busy, ack);
    end
    for (int d = 0; d < 3; d++) push_all(d, 32'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); n_chk++;
      if (rd[e.d][e.p] !== e.v) begin
        n_fail++; $display("FAIL reset_read: dut%0d rd%0d got %h want %h", e.d, e.p, rd[e.d][e.p], e.v);
      end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin bc[d] = 0; ac[d] = 0; end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin bc[d] += int'(busy[d]); ac[d] += int'(ack[d]); end
    end
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (bc[d] != (d == 1 ? 64 : 32) || ac[d] != 1) begin
        n_fail++; $display("FAIL reset_clear: dut%0d busy_cycles=%0d acks=%0d want %0d and 1",
                           d, bc[d], ac[d], (d == 1 ? 64 : 32));
      end
    end
  endtask

  task automatic test_write_latency();
    exp_t e;
    cyc();
    raddr = {6'd5, 6'd5, 6'd5};
    we = 2'b01; waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    push_all(0, 32'h0); push_all(1, 32'hDEADBEEF); push_all(2, 32'h0);
    for (int c = 0; c < 4; c++) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); n_chk++;
        if (rd[e.d][e.p] !== e.v) begin
          n_fail++; $display("FAIL write_latency c%0d: dut%0d rd%0d got %h want %h", c, e.d, e.p, rd[e.d][e.p], e.v);
        end
      end
      if (c == 3) break;
      cyc(); we = '0;
      if (c == 1) cyc();
      @(negedge clk);
      for (int d = 0; d < 3; d++) push_all(d, 32'hDEADBEEF);
    end
  endtask

  task automatic test_same_addr();
    exp_t e;
    cyc();
    raddr = {6'd7, 6'd7, 6'd7};
    we = 2'b11; waddr[0] = 6'd7; waddr[1] = 6'd7; wdata[0] = 32'h11; wdata[1] = 32'h22;
    @(negedge clk);
    push_all(1, 32'h22);
    for (int c = 0; c < 4; c++) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); n_chk++;
        if (rd[e.d][e.p] !== e.v) begin
          n_fail++; $display("FAIL same_addr c%0d: dut%0d rd%0d got %h want %h", c, e.d, e.p, rd[e.d][e.p], e.v);
        end
      end
      if (c == 3) break;
      cyc(); we = '0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) push_all(d, 32'h22);
    end
  endtask

  task automatic test_x0_fp();
    exp_t e;
    cyc();
    raddr[0] = 6'h00; raddr[1] = 6'h20; raddr[2] = 6'h20;
    we = 2'b11; waddr[0] = 6'h00; wdata[0] = 32'hFFFFFFFF; waddr[1] = 6'h20; wdata[1] = 32'hAB;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      push_all(0, 32'h0); push_all(2, 32'h0);
      push(1, 0, 32'h0); push(1, 1, 32'hAB); push(1, 2, 32'hAB);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); n_chk++;
        if (rd[e.d][e.p] !== e.v) begin
          n_fail++; $display("FAIL x0_fp c%0d: dut%0d rd%0d got %h want %h", c, e.d, e.p, rd[e.d][e.p], e.v);
        end
      end
      cyc(); we = '0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cyc();
    raddr = {6'd10, 6'd10, 6'd10};
    we = 2'b01; waddr[0] = 6'd10; wdata[0] = 32'hAAAA0001;
    cyc();
    wdata[0] = 32'hBBBB0002;
    @(negedge clk);
    push_all(0, 32'hAAAA0001); push_all(1, 32'hBBBB0002); push_all(2, 32'hAAAA0001);
    for (int c = 0; c < 3; c++) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); n_chk++;
        if (rd[e.d][e.p] !== e.v) begin
          n_fail++; $display("FAIL back_to_back c%0d: dut%0d rd%0d got %h want %h", c, e.d, e.p, rd[e.d][e.p], e.v);
        end
      end
      if (c == 2) break;
      cyc(); we = '0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) push_all(d, 32'hBBBB0002);
    end
  endtask

  task automatic test_clear();
    int bc[3], ac[3];
    exp_t e;
    for (int r = 1; r <= 31; r += 2) begin
      cyc();
      we = (r < 31) ? 2'b11 : 2'b01;
      waddr[0] = 6'(r);     wdata[0] = 32'h1000_0000 | r;
      waddr[1] = 6'(r + 1); wdata[1] = 32'h1000_0000 | (r + 1);
    end
    cyc(); we = '0;
    cyc();
    raddr[0] = 6'd1; raddr[1] = 6'd17; raddr[2] = 6'd31;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      push(d, 0, 32'h1000_0001); push(d, 1, 32'h1000_0011); push(d, 2, 32'h1000_001F);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); n_chk++;
      if (rd[e.d][e.p] !== e.v) begin
        n_fail++; $display("FAIL clear_preload: dut%0d rd%0d got %h want %h", e.d, e.p, rd[e.d][e.p], e.v);
      end
    end
    cyc(); clear_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 3'b000) begin
      n_fail++; $display("FAIL clear_pre_busy: busy=%b want 000", busy);
    end
    cyc();
    we = 2'b01; waddr[0] = 6'd3; wdata[0] = 32'h333;
    for (int d = 0; d < 3; d++) begin bc[d] = 0; ac[d] = 0; end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin bc[d] += int'(busy[d]); ac[d] += int'(ack[d]); end
      cyc(); we = '0;
    end
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (bc[d] != (d == 1 ? 64 : 32) || ac[d] != 1) begin
        n_fail++; $display("FAIL clear_held: dut%0d busy_cycles=%0d acks=%0d want %0d and 1",
                           d, bc[d], ac[d], (d == 1 ? 64 : 32));
      end
    end
    clear_req = 1'b0;
    for (int b = 0; b < 64; b += 3) begin
      raddr[0] = 6'(b); raddr[1] = 6'(b + 1); raddr[2] = 6'(b + 2);
      @(negedge clk);
      for (int d = 0; d < 3; d++) push_all(d, 32'h0);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); n_chk++;
        if (rd[e.d][e.p] !== e.v) begin
          n_fail++; $display("FAIL clear_zero a%0d: dut%0d rd%0d got %h want %h", b + e.p, e.d, e.p, rd[e.d][e.p], e.v);
        end
      end
      cyc();
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    cyc();
    raddr = {6'd9, 6'd9, 6'd9};
    we = 2'b10; waddr[1] = 6'd9; wdata[1] = 32'h1234;
    @(negedge clk);
    push_all(0, 32'h0); push_all(1, 32'h1234); push_all(2, 32'h0);
    for (int c = 0; c < 2; c++) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); n_chk++;
        if (rd[e.d][e.p] !== e.v) begin
          n_fail++; $display("FAIL bypass c%0d: dut%0d rd%0d got %h want %h", c, e.d, e.p, rd[e.d][e.p], e.v);
        end
      end
      if (c == 1) break;
      cyc(); we = '0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) push_all(d, 32'h1234);
    end
  endtask

  task automatic test_reset_mid_clear();
    int bc[3], ac[3];
    exp_t e;
    cyc();
    raddr = {6'd20, 6'd20, 6'd20};
    we = 2'b01; waddr[0] = 6'd20; wdata[0] = 32'h55;
    cyc(); we = '0;
    cyc(); clear_req = 1'b1;
    cyc(); clear_req = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    @(negedge clk);
    n_chk++;
    if (busy !== 3'b111) begin
      n_fail++; $display("FAIL midclear_busy: busy=%b want 111", busy);
    end
    for (int d = 0; d < 3; d++) push_all(d, 32'h55);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); n_chk++;
      if (rd[e.d][e.p] !== e.v) begin
        n_fail++; $display("FAIL midclear_read: dut%0d rd%0d got %h want %h", e.d, e.p, rd[e.d][e.p], e.v);
      end
    end
    #1; rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) push_all(d, 32'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); n_chk++;
      if (rd[e.d][e.p] !== e.v) begin
        n_fail++; $display("FAIL midclear_rst_read: dut%0d rd%0d got %h want %h", e.d, e.p, rd[e.d][e.p], e.v);
      end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin bc[d] = 0; ac[d] = 0; end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin bc[d] += int'(busy[d]); ac[d] += int'(ack[d]); end
    end
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (bc[d] != (d == 1 ? 64 : 32) || ac[d] != 1) begin
        n_fail++; $display("FAIL midclear_restart: dut%0d busy_cycles=%0d acks=%0d want %0d and 1",
                           d, bc[d], ac[d], (d == 1 ? 64 : 32));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_same_addr();
    test_x0_fp();
    test_back_to_back();
    test_clear();
    test_bypass();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
